// File: rtl/keyboard_wrapper.sv
// -----------------------------------------------------------------------------
// keyboard_wrapper
// PS/2 keyboard receiver front end for the player-piano design.
// The asynchronous PS/2 lines are brought into the Clock domain. The 11-bit
// frames are deframed on falling edges of the synchronized PS2Clk. The scan
// code of each released key (the byte that follows a 0xF0 break prefix) is
// then reported with a one-cycle Valid strobe.
//
// Ports:
//   Clock        in   system clock (50 MHz nominal), rising-edge logic
//   btnCpuReset  in   synchronous active-low reset
//   PS2Clk       in   PS/2 clock from keyboard, asynchronous, idles high
//   PS2Data      in   PS/2 data from keyboard, asynchronous, idles high
//   ScanData     out  [7:0] scan code of the most recently released key
//   JB           out  [1:0] debug: {synced PS2Data, synced PS2Clk}
//   Valid        out  one-cycle strobe, ScanData has just been updated
// -----------------------------------------------------------------------------
module keyboard_wrapper #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       Clock,
    input  logic       btnCpuReset,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    output logic [7:0] ScanData,
    output logic [1:0] JB,
    output logic       Valid
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   clk_prev_r;

    state_t                 state_r,  state_s;
    logic [3:0]             count_r,  count_s;
    logic [7:0]             shift_r,  shift_s;
    logic [TW-1:0]          tmo_r,    tmo_s;
    logic                   brk_r,    brk_s;
    logic [7:0]             scan_r,   scan_s;
    logic                   valid_r,  valid_s;

    logic                   clk_synced_s;
    logic                   data_synced_s;
    logic                   fall_s;

    assign clk_synced_s  = clk_sync_r[SYNC_STAGES-1];
    assign data_synced_s = data_sync_r[SYNC_STAGES-1];
    assign fall_s        = clk_prev_r & ~clk_synced_s;

    assign ScanData = scan_r;
    assign Valid    = valid_r;
    assign JB       = {data_synced_s, clk_synced_s};

    // Synchronizer chains for both PS/2 lines plus the previous synced clock level
    always_ff @(posedge Clock) begin
        if (!btnCpuReset) begin
            clk_sync_r  <= {SYNC_STAGES{1'b1}};
            data_sync_r <= {SYNC_STAGES{1'b1}};
            clk_prev_r  <= 1'b1;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], PS2Clk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], PS2Data};
            clk_prev_r  <= clk_synced_s;
        end
    end

    // Receiver, decoder and output state registers
    always_ff @(posedge Clock) begin
        if (!btnCpuReset) begin
            state_r <= ST_IDLE;
            count_r <= 4'd0;
            shift_r <= 8'h00;
            tmo_r   <= '0;
            brk_r   <= 1'b0;
            scan_r  <= 8'h00;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            shift_r <= shift_s;
            tmo_r   <= tmo_s;
            brk_r   <= brk_s;
            scan_r  <= scan_s;
            valid_r <= valid_s;
        end
    end

    // Frame deframing, idle timeout and break-prefix decode
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        shift_s = shift_r;
        tmo_s   = tmo_r;
        brk_s   = brk_r;
        scan_s  = scan_r;
        valid_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                tmo_s = '0;
                if (fall_s && !data_synced_s) begin
                    state_s = ST_RECV;
                    count_s = 4'd1;
                    shift_s = 8'h00;
                end else begin
                    // a high data bit on a falling edge is a false start
                    state_s = ST_IDLE;
                end
            end

            ST_RECV: begin
                if (fall_s) begin
                    tmo_s = '0;
                    if (count_r == 4'd10) begin
                        // eleventh edge carries the stop bit
                        state_s = ST_IDLE;
                        count_s = 4'd0;
                        if (data_synced_s) begin
                            case (shift_r)
                                8'hF0: brk_s = 1'b1;
                                8'hE0: brk_s = brk_r;
                                default: begin
                                    if (brk_r) begin
                                        scan_s  = shift_r;
                                        valid_s = 1'b1;
                                        brk_s   = 1'b0;
                                    end else begin
                                        brk_s = brk_r;
                                    end
                                end
                            endcase
                        end else begin
                            // bad stop bit: drop the frame, keep the break flag
                            brk_s = brk_r;
                        end
                    end else begin
                        // counts 1..8 carry data (LSB first); count 9 is parity,
                        // which is not checked and so is not stored
                        if (count_r <= 4'd8) begin
                            shift_s = {data_synced_s, shift_r[7:1]};
                        end else begin
                            shift_s = shift_r;
                        end
                        count_s = count_r + 4'd1;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    state_s = ST_IDLE;
                    count_s = 4'd0;
                    shift_s = 8'h00;
                    tmo_s   = '0;
                end else begin
                    tmo_s = tmo_r + TW'(1);
                end
            end

            default: begin
                state_s = ST_IDLE;
                count_s = 4'd0;
                shift_s = 8'h00;
                tmo_s   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_keyboard_wrapper.sv
// -----------------------------------------------------------------------------
// tb_keyboard_wrapper
// Drives PS/2 frames into keyboard_wrapper. Each sent byte goes into a
// byte-level model of the break-prefix rules. The model yields the list of
// scan codes that must be reported. A monitor collects every Valid pulse.
// -----------------------------------------------------------------------------
module tb_keyboard_wrapper;

    localparam int TMO = 5000;
    localparam int SS  = 2;

    logic       Clock       = 1'b0;
    logic       btnCpuReset = 1'b0;
    logic       PS2Clk      = 1'b1;
    logic       PS2Data     = 1'b1;
    logic [7:0] ScanData;
    logic [1:0] JB;
    logic       Valid;

    keyboard_wrapper #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SS)) dut (
        .Clock      (Clock),
        .btnCpuReset(btnCpuReset),
        .PS2Clk     (PS2Clk),
        .PS2Data    (PS2Data),
        .ScanData   (ScanData),
        .JB         (JB),
        .Valid      (Valid)
    );

    always #10 Clock = ~Clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    bit         model_brk  = 1'b0;
    logic [7:0] model_scan = 8'h00;

    int         dbl_cnt        = 0;
    int         stab_err       = 0;
    logic       prev_valid     = 1'b0;
    logic [7:0] held           = 8'h00;
    int         last_valid_cyc = 0;
    int         stop_cyc       = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    // monitor: collect pulses, catch back-to-back Valid and ScanData drifting
    always @(negedge Clock) begin
        if (Valid === 1'b1) begin
            got_q.push_back(ScanData);
            last_valid_cyc = cyc;
            if (prev_valid) dbl_cnt++;
            held = ScanData;
        end else if (btnCpuReset === 1'b0) begin
            held = ScanData;
        end else if (ScanData !== held) begin
            stab_err++;
            held = ScanData;
        end
        prev_valid = (Valid === 1'b1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            PS2Data = bits[i];
            wait_clk(half);
            PS2Clk   = 1'b0;
            stop_cyc = cyc;
            wait_clk(half);
            PS2Clk = 1'b1;
        end
        PS2Data = 1'b1;
    endtask

    // send one frame (random parity) and apply the byte to the model
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int half);
        logic [10:0] bits;
        bits = {stop_ok, 1'($urandom_range(0, 1)), b, 1'b0};
        send_bits(bits, 11, half);
        if (stop_ok) begin
            if (b == 8'hF0) begin
                model_brk = 1'b1;
            end else if (b != 8'hE0 && model_brk) begin
                exp_q.push_back(b);
                model_scan = b;
                model_brk  = 1'b0;
            end
        end
    endtask

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        int vbad;
        vbad = 0;
        btnCpuReset = 1'b0;
        PS2Clk = 1'b1;
        PS2Data = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wait_clk(1);
            if (Valid !== 1'b0) vbad++;
        end
        total++; if (vbad != 0) begin bad++; $display("FAIL reset_valid_low: %0d cycles high, need 0", vbad); end
        total++; if (ScanData !== 8'h00) begin bad++; $display("FAIL reset_scan: got %h need 00", ScanData); end
        total++; if (JB !== 2'b11) begin bad++; $display("FAIL reset_jb: got %b need 11", JB); end
        model_brk = 1'b0;
        model_scan = 8'h00;
        clear_q();
        btnCpuReset = 1'b1;
        wait_clk(20);
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL reset_release: %0d pulses, need 0", got_q.size()); end
    endtask

    task automatic test_jb();
        clear_q();
        PS2Data = 1'b0;
        wait_clk(SS + 2);
        total++; if (JB !== 2'b01) begin bad++; $display("FAIL jb_data_low: got %b need 01", JB); end
        PS2Data = 1'b1;
        PS2Clk = 1'b0;   // falling edge with data high: false start
        wait_clk(SS + 2);
        total++; if (JB !== 2'b10) begin bad++; $display("FAIL jb_clk_low: got %b need 10", JB); end
        PS2Clk = 1'b1;
        wait_clk(SS + 2);
        total++; if (JB !== 2'b11) begin bad++; $display("FAIL jb_idle: got %b need 11", JB); end
        // immediately follow with a break sequence; a false start would misalign it
        send_frame(8'hF0, 1'b1, 50);
        send_frame(8'h1C, 1'b1, 50);
        wait_clk(10);
        total++; if (got_q.size() != 1 || got_q[0] !== 8'h1C)
            begin bad++; $display("FAIL false_start: got %0d pulses first %h, need 1 pulse 1c", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    endtask

    task automatic test_break_key();
        int lat;
        clear_q();
        send_frame(8'hF0, 1'b1, 250);
        wait_clk(10);
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL f0_no_valid: %0d pulses, need 0", got_q.size()); end
        send_frame(8'h54, 1'b1, 250);
        wait_clk(10);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL break_key_count: got %0d need %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL break_key_code[%0d]: got %h need %h", i, got_q[i], exp_q[i]); end
        end
        lat = last_valid_cyc - stop_cyc;
        total++; if (lat < 1 || lat > SS + 2) begin bad++; $display("FAIL latency: got %0d cycles need 1..%0d", lat, SS + 2); end
    endtask

    task automatic test_repeat();
        clear_q();
        send_frame(8'hF0, 1'b1, 50);
        wait_clk(100);
        send_frame(8'h54, 1'b1, 50);
        wait_clk(30);
        send_frame(8'hF0, 1'b1, 50);
        wait_clk(100);
        send_frame(8'h5A, 1'b1, 50);
        wait_clk(200);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL repeat_count: got %0d need %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL repeat_code[%0d]: got %h need %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (ScanData !== model_scan) begin bad++; $display("FAIL repeat_hold: got %h need %h", ScanData, model_scan); end
    endtask

    task automatic test_make_only();
        clear_q();
        send_frame(8'h5A, 1'b1, 50);
        wait_clk(20);
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL make_only_valid: %0d pulses need 0", got_q.size()); end
        total++; if (ScanData !== model_scan) begin bad++; $display("FAIL make_only_hold: got %h need %h", ScanData, model_scan); end
    endtask

    task automatic test_bad_stop();
        clear_q();
        send_frame(8'hF0, 1'b1, 50);
        send_frame(8'h54, 1'b0, 50);
        wait_clk(20);
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL bad_stop_valid: %0d pulses need 0", got_q.size()); end
        send_frame(8'h5A, 1'b1, 50);
        wait_clk(20);
        total++; if (got_q.size() != 1 || got_q[0] !== 8'h5A)
            begin bad++; $display("FAIL bad_stop_next: got %0d pulses first %h need 1 pulse 5a", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    endtask

    task automatic test_prefix();
        clear_q();
        send_frame(8'hF0, 1'b1, 40);
        send_frame(8'hE0, 1'b1, 40);
        send_frame(8'h6B, 1'b1, 40);
        send_frame(8'hF0, 1'b1, 40);
        send_frame(8'hF0, 1'b1, 40);
        send_frame(8'h1C, 1'b1, 40);
        wait_clk(20);
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL prefix_count: got %0d need 2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL prefix_code[%0d]: got %h need %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_timeout();
        clear_q();
        send_bits(11'h2A6, 5, 50);
        wait_clk(TMO + 100);
        send_frame(8'hF0, 1'b1, 50);
        send_frame(8'h5A, 1'b1, 50);
        wait_clk(20);
        total++; if (got_q.size() != 1 || got_q[0] !== 8'h5A)
            begin bad++; $display("FAIL timeout: got %0d pulses first %h need 1 pulse 5a", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    endtask

    task automatic test_reset_mid();
        clear_q();
        send_frame(8'hF0, 1'b1, 50);
        send_frame(8'h33, 1'b1, 50);
        send_frame(8'hF0, 1'b1, 50);
        send_bits(11'h2A6, 5, 50);
        btnCpuReset = 1'b0;
        wait_clk(5);
        total++; if (ScanData !== 8'h00) begin bad++; $display("FAIL mid_reset_scan: got %h need 00", ScanData); end
        total++; if (Valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b need 0", Valid); end
        total++; if (JB !== 2'b11) begin bad++; $display("FAIL mid_reset_jb: got %b need 11", JB); end
        btnCpuReset = 1'b1;
        model_brk = 1'b0;
        model_scan = 8'h00;
        clear_q();
        wait_clk(5);
        send_frame(8'h5A, 1'b1, 50);
        wait_clk(20);
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL mid_reset_brk_cleared: %0d pulses need 0", got_q.size()); end
        send_frame(8'hF0, 1'b1, 50);
        send_frame(8'h5A, 1'b1, 50);
        wait_clk(20);
        total++; if (got_q.size() != 1 || got_q[0] !== 8'h5A)
            begin bad++; $display("FAIL mid_reset_after: got %0d pulses first %h need 1 pulse 5a", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int r;
        clear_q();
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3)       b = 8'hF0;
            else if (r == 3) b = 8'hE0;
            else             b = 8'($urandom_range(0, 255));
            send_frame(b, ($urandom_range(0, 7) != 0), 20 + $urandom_range(0, 20));
            wait_clk(2 + $urandom_range(0, 30));
        end
        wait_clk(20);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL random_count: got %0d need %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL random_code[%0d]: got %h need %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (ScanData !== model_scan) begin bad++; $display("FAIL random_hold: got %h need %h", ScanData, model_scan); end
    endtask

    task automatic test_invariants();
        total++; if (dbl_cnt != 0) begin bad++; $display("FAIL valid_back_to_back: got %0d need 0", dbl_cnt); end
        total++; if (stab_err != 0) begin bad++; $display("FAIL scan_stability: got %0d changes need 0", stab_err); end
    endtask

    initial begin
        test_reset();
        test_jb();
        test_break_key();
        test_repeat();
        test_make_only();
        test_bad_stop();
        test_prefix();
        test_timeout();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
